// File: rtl/display_bcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_bcd_ctrl
// Description : Converts one binary word per handshake to BCD with the
//               shift-add-3 method, then drives NDIG 7-segment decoders
//               (BCD code, blank and minus-sign per digit) with leading-zero
//               blanking, a minus sign left of the top digit and overflow
//               indication. Optional blinking is enabled by defining
//               DISP_BLINK_EN, which adds the blink_on input and BLINK_DIV.
// Revision    : 1.0 - initial release
// ============================================================================
module display_bcd_ctrl #(
    parameter int W         = 8,
    parameter int NDIG      = 4
`ifdef DISP_BLINK_EN
    ,
    parameter int BLINK_DIV = 25
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef DISP_BLINK_EN
    input  logic                blink_on,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
    input  logic                in_signed,
    output logic [4*NDIG-1:0]   dig_bcd,
    output logic [NDIG-1:0]     dig_blank,
    output logic [NDIG-1:0]     dig_sign,
    output logic                busy,
    output logic                ovf
);

    localparam int BCD_W = 4 * NDIG;
    localparam int CNT_W = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ABS  = 2'd1,
        S_CONV = 2'd2,
        S_LOAD = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [W-1:0]       word;
    logic               word_signed;
    logic               neg;
    logic [W-1:0]       mag;
    logic [BCD_W-1:0]   bcd;
    logic               lost;
    logic [CNT_W-1:0]   cnt;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic [W-1:0]       mag_shift;
    logic               carry_out;

    logic [BCD_W-1:0]   load_bcd;
    logic [NDIG-1:0]    load_blank;
    logic [NDIG-1:0]    load_sign;
    logic               load_ovf;
    logic [NDIG-1:0]    blank_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> ABS -> CONV (W cycles) -> LOAD -> IDLE
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid && in_ready) state_next = S_ABS;
            S_ABS:   state_next = S_CONV;
            S_CONV:  if (cnt == CNT_W'(W - 1)) state_next = S_LOAD;
            S_LOAD:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Registered handshake flags, derived from the upcoming state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            in_ready <= (state_next == S_IDLE);
            busy     <= (state_next != S_IDLE);
        end
    end

    // One shift-add-3 step; a 1 leaving the top nibble means the value
    // needs more digits than the accumulator holds
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < NDIG; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[BCD_W-2:0], mag[W-1]};
        mag_shift = {mag[W-2:0], 1'b0};
        carry_out = bcd_adj[BCD_W-1];
    end

    // Conversion datapath: capture, magnitude, then W shift steps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word        <= '0;
            word_signed <= 1'b0;
            neg         <= 1'b0;
            mag         <= '0;
            bcd         <= '0;
            lost        <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        word        <= in_data;
                        word_signed <= in_signed;
                    end
                end
                S_ABS: begin
                    // -2^(W-1) negates to itself, which reads correctly as unsigned
                    neg  <= word_signed & word[W-1];
                    mag  <= (word_signed && word[W-1]) ? -word : word;
                    bcd  <= '0;
                    lost <= 1'b0;
                    cnt  <= '0;
                end
                S_CONV: begin
                    bcd  <= bcd_shift;
                    mag  <= mag_shift;
                    lost <= lost | carry_out;
                    cnt  <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Display composition: digit count, sign placement and overflow
    always_comb begin
        int  n;
        logic fits;
        n          = 1;
        load_bcd   = '0;
        load_blank = '0;
        load_sign  = '0;
        load_ovf   = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (bcd[4*k +: 4] != 4'd0) n = k + 1;
        end
        fits = !lost && ((n + (neg ? 1 : 0)) <= NDIG);
        if (fits) begin
            for (int k = 0; k < NDIG; k++) begin
                if (k < n) begin
                    load_bcd[4*k +: 4] = bcd[4*k +: 4];
                end else if (neg && (k == n)) begin
                    load_sign[k] = 1'b1;
                end else begin
                    load_blank[k] = 1'b1;
                end
            end
        end else begin
            load_sign = '1;
            load_ovf  = 1'b1;
        end
    end

    // Output registers change only in LOAD, so no partial value is shown
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dig_bcd  <= '0;
            blank_q  <= '1;
            dig_sign <= '0;
            ovf      <= 1'b0;
        end else if (state == S_LOAD) begin
            dig_bcd  <= load_bcd;
            blank_q  <= load_blank;
            dig_sign <= load_sign;
            ovf      <= load_ovf;
        end
    end

`ifdef DISP_BLINK_EN
    localparam int BLINK_CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_CW-1:0] blink_cnt;
    logic                blink_phase;

    // Free-running blink timer; phase 1 is the dark half-period
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_CW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    assign dig_blank = blank_q | {NDIG{blink_on & blink_phase}};
`else
    assign dig_blank = blank_q;
`endif

endmodule
`default_nettype wire
